// File: rtl/apb_pkg.sv
// Shared APB completer types: FSM state, PPROT bit positions and the
// data-width dependent address LSB.
package apb_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam int PROT_PRIV  = 0;
  localparam int PROT_NSEC  = 1;
  localparam int PROT_INSTR = 2;

  // Lowest PADDR bit that selects a register (byte offset bits below it).
  function automatic int lsb_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_strb_reg.sv
// Purpose: one DATA_W register with per-byte write strobes and a write pulse.
// Latency: data committed at the write edge, pulse high the following cycle.
// Backpressure: none, accepts a write every cycle.
module apb_strb_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   strb,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q,
  output logic                  pulse
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= RESET_VAL;
      pulse <= 1'b0;
    end else begin
      // An all-zero strobe is a no-op write and must not look like an update.
      pulse <= we && (|strb);
      if (we) begin
        for (int b = 0; b < DATA_W / 8; b++) begin
          if (strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/apb_reg_completer.sv
// Purpose: APB4 completer terminating one port in NUM_REGS strobe-writable registers.
// Latency: setup + (WAIT_STATES+1) access cycles; wr_pulse one cycle after completion.
// Backpressure: PREADY held low for WAIT_STATES access cycles, registered.
module apb_reg_completer
  import apb_pkg::*;
#(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 8,
  parameter int                WAIT_STATES = 0,
  parameter bit                PROT_CHECK  = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic [ADDR_W-1:0]            PADDR,
  input  logic                         PWRITE,
  input  logic [DATA_W-1:0]            PWDATA,
  input  logic [DATA_W/8-1:0]          PSTRB,
  input  logic [2:0]                   PPROT,
  output logic [DATA_W-1:0]            PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int LSB   = lsb_of(DATA_W);
  localparam int IDX_W = ADDR_W - LSB;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
    logic             write;
  } txn_t;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ready_q, ready_d;
  txn_t                txn_q, txn_d;
  logic [IDX_W-1:0]    idx;
  logic                misalign;
  logic                err;
  logic                wr_go;
  logic [NUM_REGS-1:0] we;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd_dat;
  logic                unused_prot;

  assign idx         = PADDR[ADDR_W-1:LSB];
  assign unused_prot = PPROT[PROT_NSEC] ^ PPROT[PROT_INSTR];

  if (LSB > 0) begin : g_align
    assign misalign = |PADDR[LSB-1:0];
  end else begin : g_noalign
    assign misalign = 1'b0;
  end

  assign err = (int'(idx) >= NUM_REGS) | misalign |
               (PROT_CHECK & PWRITE & ~PPROT[PROT_PRIV]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    txn_d   = txn_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d     = ACCESS;
          cnt_d       = 4'(WAIT_STATES);
          ready_d     = (WAIT_STATES == 0);
          txn_d.idx   = idx;
          txn_d.err   = err;
          txn_d.write = PWRITE;
        end
      end
      ACCESS: begin
        // Losing PSEL mid-access abandons the transfer silently.
        if (!PSEL || ready_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          ready_d = (cnt_q == 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      txn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      txn_q   <= txn_d;
    end
  end

  assign wr_go = (state_q == ACCESS) & PSEL & PENABLE & ready_q &
                 txn_q.write & ~txn_q.err;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign we[i] = wr_go && (txn_q.idx == IDX_W'(i));

    apb_strb_reg #(
      .DATA_W    (DATA_W),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk   (PCLK),
      .rst_n (PRESETn),
      .we    (we[i]),
      .strb  (PSTRB),
      .wdata (PWDATA),
      .q     (regs[i]),
      .pulse (wr_pulse[i])
    );

    assign reg_q[i*DATA_W +: DATA_W] = regs[i];
  end

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (txn_q.idx == IDX_W'(i)) rd_dat = regs[i];
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = ready_q & txn_q.err;
  assign PRDATA  = (ready_q && !txn_q.err && !txn_q.write) ? rd_dat : '0;

endmodule
